// File: rtl/mips_reg_file.sv
// mips_reg_file: 32 x 32-bit MIPS32 general-purpose register file.
//   Two asynchronous read ports (rs/rt), one synchronous write port,
//   register $0 hardwired to zero, synchronous active-high reset.
// Optional feature macro: REGFILE_DEBUG_EN
//   Adds a third combinational read port (dbg_addr/dbg_data) and a
//   CNT_W-bit committed-write counter (wr_count).
// Ports:
//   clk         in   system clock, rising-edge state updates
//   rst         in   synchronous reset, active-high, priority over writes
//   reg_write   in   write enable from the control unit
//   read_reg1   in   rs index
//   read_reg2   in   rt index
//   write_reg   in   destination index (rt, rd or 31 for jal)
//   write_data  in   write-back value
//   read_data1  out  contents of read_reg1 (combinational)
//   read_data2  out  contents of read_reg2 (combinational)
//   dbg_addr    in   debug read index          (REGFILE_DEBUG_EN only)
//   dbg_data    out  contents of dbg_addr      (REGFILE_DEBUG_EN only)
//   wr_count    out  committed-write counter   (REGFILE_DEBUG_EN only)
module mips_reg_file #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
`ifdef REGFILE_DEBUG_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              w_commit;

  // A write only commits to a non-zero destination; reg_write=0 masks X on index/data.
  assign w_commit = reg_write && (write_reg != '0);

  // Storage update; reset clears every entry and drops a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Read ports: no write bypass, so same-cycle reads see the old value.
  assign read_data1 = (read_reg1 == '0) ? '0 : r_regs[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : r_regs[read_reg2];

`ifdef REGFILE_DEBUG_EN
  logic [CNT_W-1:0] r_wr_count;

  // Committed-write counter, wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_wr_count <= r_wr_count + CNT_W'(1);
    end
  end

  assign wr_count = r_wr_count;
  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
`endif

endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: directed + randomized self-checking bench for mips_reg_file.
// Builds with or without REGFILE_DEBUG_EN; debug build uses CNT_W=4.
module tb_mips_reg_file;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              reg_write;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
`ifdef REGFILE_DEBUG_EN
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wr_count;
`endif

  mips_reg_file #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
`ifdef REGFILE_DEBUG_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_write (reg_write),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_data1(read_data1),
    .read_data2(read_data2)
`ifdef REGFILE_DEBUG_EN
    ,
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_count  (wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register values plus a write tally.
  int unsigned m_reg [32];
  int unsigned m_cnt;

  int n_err;
  int n_chk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural read rule: $0 always reads zero.
  function automatic logic [31:0] m_read(input int unsigned idx);
    return (idx == 0) ? 32'd0 : 32'(m_reg[idx]);
  endfunction

  // Model the effect of one rising edge given the currently driven inputs.
  task automatic m_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 0;
      m_cnt = 0;
    end else if (reg_write && write_reg != 0) begin
      m_reg[int'(write_reg)] = int'(write_data);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  // Apply one clock edge, update the model, and leave time past the edge.
  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      read_reg2 = 5'(31 - i);
`ifdef REGFILE_DEBUG_EN
      dbg_addr  = 5'(i);
`endif
      #1;
      chk({tag, "_rd1"}, read_data1, m_read(i));
      chk({tag, "_rd2"}, read_data2, m_read(31 - i));
`ifdef REGFILE_DEBUG_EN
      chk({tag, "_dbg"}, dbg_data, m_read(i));
`endif
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    reg_write = 1'b1; write_reg = a; write_data = d;
    tick();
    reg_write = 1'b0;
  endtask

  initial begin
    n_err = 0; n_chk = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = 0;
    rst = 1'b1; reg_write = 1'b0; read_reg1 = '0; read_reg2 = '0;
    write_reg = '0; write_data = '0;
`ifdef REGFILE_DEBUG_EN
    dbg_addr = '0;
`endif

    // Initial reset: all entries read zero.
    tick();
    rst = 1'b0;
    check_all("reset");
`ifdef REGFILE_DEBUG_EN
    chk("reset_cnt", 32'(wr_count), 32'd0);
`endif

    // Preload r5 then a one-cycle reset clears it.
    do_write(5'd5, 32'hDEADBEEF);
    read_reg1 = 5'd5; #1;
    chk("preload_r5", read_data1, 32'hDEADBEEF);
    rst = 1'b1; tick(); rst = 1'b0;
    read_reg1 = 5'd5; #1;
    chk("reset_r5", read_data1, 32'h0);
    check_all("reset2");

    // Basic write/read on both ports, neighbour untouched.
    do_write(5'd8, 32'h12345678);
    read_reg1 = 5'd8; read_reg2 = 5'd8; #1;
    chk("basic_rd1", read_data1, 32'h12345678);
    chk("basic_rd2", read_data2, 32'h12345678);
    read_reg1 = 5'd9; #1;
    chk("basic_r9", read_data1, 32'h0);

    // $0 protection.
    do_write(5'd0, 32'hFFFFFFFF);
    read_reg1 = 5'd0; read_reg2 = 5'd0; #1;
    chk("zero_rd1", read_data1, 32'h0);
    chk("zero_rd2", read_data2, 32'h0);
`ifdef REGFILE_DEBUG_EN
    chk("zero_cnt", 32'(wr_count), 32'd1);
`endif

    // jal target, no bypass: old value before the edge, new after.
    read_reg2 = 5'd31;
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h00400008; #1;
    chk("jal_before", read_data2, 32'h0);
    tick();
    reg_write = 1'b0; #1;
    chk("jal_after", read_data2, 32'h00400008);

    // Same no-bypass check with a non-zero old value.
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'hCAFEF00D; #1;
    chk("nobyp_before", read_data2, 32'h00400008);
    tick();
    reg_write = 1'b0; #1;
    chk("nobyp_after", read_data2, 32'hCAFEF00D);

    // Reset priority over a same-cycle write.
    do_write(5'd3, 32'h13579BDF);
    rst = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hA5A5A5A5;
    tick();
    rst = 1'b0; reg_write = 1'b0;
    read_reg1 = 5'd3; #1;
    chk("rstpri_r3", read_data1, 32'h0);
`ifdef REGFILE_DEBUG_EN
    chk("rstpri_cnt", 32'(wr_count), 32'd0);
`endif

    // X-safety: disabled write with X index/data leaves state alone.
    do_write(5'd12, 32'h0BADC0DE);
    reg_write = 1'b0; write_reg = 'x; write_data = 'x;
    tick();
    tick();
    check_all("xsafe");

    // Counter wrap: 17 committed writes to r1..r17.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      do_write(5'(k), 32'h1000_0000 + 32'(k));
    end
    read_reg1 = 5'd17; #1;
    chk("wrap_r17", read_data1, 32'h1000_0011);
`ifdef REGFILE_DEBUG_EN
    dbg_addr = 5'd17; #1;
    chk("wrap_dbg17", dbg_data, 32'h1000_0011);
    chk("wrap_cnt", 32'(wr_count), 32'd1);
`endif

    // Randomized traffic against the model; reads checked before each edge.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 31) == 0);
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      write_data = $urandom;
      read_reg1  = 5'($urandom);
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom);
`ifdef REGFILE_DEBUG_EN
      dbg_addr   = 5'($urandom);
`endif
      #1;
      chk("rand_rd1", read_data1, m_read(int'(read_reg1)));
      chk("rand_rd2", read_data2, m_read(int'(read_reg2)));
`ifdef REGFILE_DEBUG_EN
      chk("rand_dbg", dbg_data, m_read(int'(dbg_addr)));
      chk("rand_cnt", 32'(wr_count), 32'(m_cnt));
`endif
      tick();
    end
    rst = 1'b0; reg_write = 1'b0;
    check_all("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- 32 x 32-bit general-purpose register file for the MIPS32 single-cycle datapath.
- Consumes the 5-bit destination index from the write-register select mux (rt, rd, or 31 for jal) and the write-back data.
- Supplies the rs/rt operands to the ALU stage through two asynchronous read ports.
- Register $0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- CNT_W, 16, width of the debug write counter (used only with REGFILE_DEBUG_EN)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- reg_write  input  1  write enable from the control unit
- read_reg1  input  ADDR_W  rs index (instr[25:21])
- read_reg2  input  ADDR_W  rt index (instr[20:16])
- write_reg  input  ADDR_W  destination index from the write-register select mux
- write_data  input  DATA_W  write-back value (ALU result, memory data or PC+4)
- read_data1  output  DATA_W  contents of read_reg1
- read_data2  output  DATA_W  contents of read_reg2
- dbg_addr  input  ADDR_W  debug read index (REGFILE_DEBUG_EN only)
- dbg_data  output  DATA_W  contents of dbg_addr (REGFILE_DEBUG_EN only)
- wr_count  output  CNT_W  committed-write counter (REGFILE_DEBUG_EN only)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Storage: 32 entries of DATA_W bits.
- Reset:
  - rst sampled high at a rising clk edge clears all 32 entries to 0 at that edge.
  - rst has priority over reg_write in the same cycle; the write is dropped.
  - Reset asserted mid-program clears state on the next edge; no partial writes.
- Write:
  - At a rising edge with rst=0 and reg_write=1 and write_reg!=0, entry[write_reg] <= write_data.
  - Write latency is one edge; the new value is visible on the read ports after that edge.
- $0 handling:
  - A write with write_reg=0 is ignored; entry 0 stays 0.
  - Reads of index 0 return 0 regardless of storage.
- Read:
  - read_data1/read_data2 are purely combinational from the current register contents; zero latency.
  - No write-to-read bypass. A read of write_reg in the same cycle as the write returns the old value. This is mandatory, because bypass would form a combinational loop in the single-cycle datapath.
- Same index: read_reg1==read_reg2 returns identical data on both ports.
- X-safety: reg_write=0 must leave every entry unchanged irrespective of X on write_reg or write_data.
- Output values after reset:
  - read_data1 = 0 and read_data2 = 0 for any index.
  - dbg_data = 0 and wr_count = 0 (debug build only).

Optional Feature:
- Macro: REGFILE_DEBUG_EN
- Defined:
  - Adds the dbg_addr/dbg_data port, a combinational third read port with the same $0 rule.
  - Adds wr_count, a CNT_W-bit register that increments by 1 at each edge where a write commits (rst=0, reg_write=1, write_reg!=0).
  - wr_count wraps from 2**CNT_W-1 to 0.
  - wr_count is cleared by rst, with rst priority over increment.
- Undefined: dbg_addr, dbg_data and wr_count are absent from the port list; there is no counter logic and core behaviour is identical.

Test Plan:
- Reset clear: preload r5=0xDEADBEEF, assert rst for 1 cycle -> read_reg1=5 gives 0x00000000; all 32 entries read 0.
- Basic write/read: reg_write=1, write_reg=8, write_data=0x12345678, one edge -> read_reg1=8 gives 0x12345678 and read_reg2=8 gives the same; r9 still reads 0.
- $0 protection: reg_write=1, write_reg=0, write_data=0xFFFFFFFF -> read_data1 for index 0 = 0; wr_count unchanged in the debug build.
- jal target and no bypass: write_reg=31, write_data=0x00400008, read_reg2=31 in the same cycle -> read_data2 shows the old value 0 before the edge and 0x00400008 after it.
- Reset priority: rst=1 and reg_write=1 with write_reg=3, write_data=0xA5A5A5A5 in the same cycle -> r3=0 after the edge; wr_count=0.
- Debug counter wrap (REGFILE_DEBUG_EN, CNT_W=4): 17 committed writes to r1..r17 (indices mod 32, skipping 0) -> wr_count=1; dbg_addr=17 gives the last written data.
